traffic_fsm: RTL and testbench

//   Main-street/side-street traffic light controller; consumes synchronized inputs
//   (sensor_sync, wr_sync, prog_sync) from the input synchronizer stage.

---
 rtl/traffic_fsm.sv | 161 ++++++++++++++++
 tb/tb_traffic_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_fsm.sv
// Main/side-street traffic light controller with walk requests and programmable intervals.
// Optional macro PED_COUNTDOWN_EN adds the walk_remain countdown output.
module traffic_fsm #(
  parameter int unsigned TW         = 4,
  parameter int unsigned T_BASE_DEF = 6,
  parameter int unsigned T_EXT_DEF  = 3,
  parameter int unsigned T_YEL_DEF  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          one_hz_en,
  input  logic          sensor_sync,
  input  logic          wr_sync,
  input  logic          prog_sync,
  input  logic [1:0]    time_sel,
  input  logic [TW-1:0] time_value,
  output logic [2:0]    main_lt,
  output logic [2:0]    side_lt,
  output logic          walk_lt,
  output logic [2:0]    state_dbg
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [TW-1:0] walk_remain
`endif
);

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_G2 = 3'd1,
    MAIN_Y  = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_GX = 3'd4,
    SIDE_Y  = 3'd5,
    WALK    = 3'd6
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] t_base_q, t_base_d;
  logic [TW-1:0] t_ext_q, t_ext_d;
  logic [TW-1:0] t_yel_q, t_yel_d;
  logic          walk_req_q, walk_req_d;
  logic [2:0]    main_lt_q, side_lt_q;
  logic          walk_lt_q;

  // A programmed interval of zero still has to last one tick.
  function automatic logic [TW-1:0] nonzero(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  function automatic logic [TW-1:0] duration(input state_t s, input logic [TW-1:0] base,
                                             input logic [TW-1:0] ext, input logic [TW-1:0] yel);
    logic [TW-1:0] d;
    case (s)
      MAIN_Y, SIDE_Y: d = yel;
      SIDE_GX, WALK:  d = ext;
      default:        d = base;
    endcase
    return nonzero(d);
  endfunction

  function automatic logic [2:0] main_of(input state_t s);
    case (s)
      MAIN_G, MAIN_G2: return LT_GRN;
      MAIN_Y:          return LT_YEL;
      default:         return LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_of(input state_t s);
    case (s)
      SIDE_G, SIDE_GX: return LT_GRN;
      SIDE_Y:          return LT_YEL;
      default:         return LT_RED;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    t_base_d   = t_base_q;
    t_ext_d    = t_ext_q;
    t_yel_d    = t_yel_q;
    walk_req_d = walk_req_q;

    if (wr_sync && (state_q != WALK)) begin
      walk_req_d = 1'b1;
    end

    if (prog_sync) begin
      case (time_sel)
        2'b00:   t_base_d = time_value;
        2'b01:   t_ext_d  = time_value;
        2'b10:   t_yel_d  = time_value;
        default: ;
      endcase
      state_d = MAIN_G;
      timer_d = nonzero(t_base_d);
    end else if (one_hz_en) begin
      // Expiry at 1 (<= guards against a stuck zero) so each state lasts exactly D ticks.
      if (timer_q <= TW'(1)) begin
        case (state_q)
          MAIN_G:  state_d = sensor_sync ? MAIN_Y : MAIN_G2;
          MAIN_G2: state_d = MAIN_Y;
          MAIN_Y:  state_d = SIDE_G;
          SIDE_G:  state_d = sensor_sync ? SIDE_GX : SIDE_Y;
          SIDE_GX: state_d = SIDE_Y;
          SIDE_Y:  state_d = walk_req_q ? WALK : MAIN_G;
          default: state_d = MAIN_G;
        endcase
        timer_d = duration(state_d, t_base_q, t_ext_q, t_yel_q);
        if (state_d == WALK) begin
          walk_req_d = 1'b0;
        end
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MAIN_G;
      timer_q    <= nonzero(TW'(T_BASE_DEF));
      t_base_q   <= TW'(T_BASE_DEF);
      t_ext_q    <= TW'(T_EXT_DEF);
      t_yel_q    <= TW'(T_YEL_DEF);
      walk_req_q <= 1'b0;
      main_lt_q  <= LT_GRN;
      side_lt_q  <= LT_RED;
      walk_lt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      t_base_q   <= t_base_d;
      t_ext_q    <= t_ext_d;
      t_yel_q    <= t_yel_d;
      walk_req_q <= walk_req_d;
      // Lights are registered from the next state so they stay aligned with state_q.
      main_lt_q  <= main_of(state_d);
      side_lt_q  <= side_of(state_d);
      walk_lt_q  <= (state_d == WALK);
    end
  end

  assign main_lt   = main_lt_q;
  assign side_lt   = side_lt_q;
  assign walk_lt   = walk_lt_q;
  assign state_dbg = state_q;

`ifdef PED_COUNTDOWN_EN
  assign walk_remain = (state_q == WALK) ? timer_q : '0;
`else
  // Countdown output not built.
`endif

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed self-checking bench for traffic_fsm: timing cycles, sensor, walk, programming, reset.
// Ticks are issued every 4 clocks; outputs are sampled just before the next tick.
module tb_traffic_fsm;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  localparam logic [2:0] S_MAIN_G  = 3'd0;
  localparam logic [2:0] S_MAIN_G2 = 3'd1;
  localparam logic [2:0] S_MAIN_Y  = 3'd2;
  localparam logic [2:0] S_SIDE_G  = 3'd3;
  localparam logic [2:0] S_SIDE_GX = 3'd4;
  localparam logic [2:0] S_SIDE_Y  = 3'd5;
  localparam logic [2:0] S_WALK    = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_hz_en;
  logic       sensor_sync;
  logic       wr_sync;
  logic       prog_sync;
  logic [1:0] time_sel;
  logic [3:0] time_value;
  logic [2:0] main_lt;
  logic [2:0] side_lt;
  logic       walk_lt;
  logic [2:0] state_dbg;
`ifdef PED_COUNTDOWN_EN
  logic [3:0] walk_remain;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  traffic_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .one_hz_en   (one_hz_en),
    .sensor_sync (sensor_sync),
    .wr_sync     (wr_sync),
    .prog_sync   (prog_sync),
    .time_sel    (time_sel),
    .time_value  (time_value),
    .main_lt     (main_lt),
    .side_lt     (side_lt),
    .walk_lt     (walk_lt),
    .state_dbg   (state_dbg)
`ifdef PED_COUNTDOWN_EN
    ,
    .walk_remain (walk_remain)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk) one_hz_en = 1'b1;
    @(negedge clk) one_hz_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val, input logic with_tick,
                      input logic with_wr);
    @(negedge clk);
    prog_sync  = 1'b1;
    time_sel   = sel;
    time_value = val;
    one_hz_en  = with_tick;
    wr_sync    = with_wr;
    @(negedge clk);
    prog_sync  = 1'b0;
    one_hz_en  = 1'b0;
    wr_sync    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Check full light state on entry, then that the state holds for exactly n ticks.
  task automatic run_state(input string nm, input logic [2:0] st, input int n,
                           input logic [2:0] m, input logic [2:0] s, input logic w,
                           input logic wr);
    n_checks++;
    if (state_dbg !== st || main_lt !== m || side_lt !== s || walk_lt !== w) begin
      n_fail++;
      $display("FAIL %s entry: state=%0d main=%b side=%b walk=%b, expected state=%0d main=%b side=%b walk=%b",
               nm, state_dbg, main_lt, side_lt, walk_lt, st, m, s, w);
    end
    if (wr) begin
      @(negedge clk) wr_sync = 1'b1;
      @(negedge clk) wr_sync = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        n_checks++;
        if (state_dbg !== st) begin
          n_fail++;
          $display("FAIL %s hold tick %0d: state=%0d, expected %0d", nm, k, state_dbg, st);
        end
      end
`ifdef PED_COUNTDOWN_EN
      n_checks++;
      if (walk_remain !== ((st == S_WALK) ? 4'(n - k) : 4'd0)) begin
        n_fail++;
        $display("FAIL %s walk_remain tick %0d: got %0d", nm, k, walk_remain);
      end
`endif
      tick();
    end
  endtask

  task automatic default_cycle(input string nm);
    run_state({nm, "_main_g"},  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state({nm, "_main_g2"}, S_MAIN_G2, 6, G, R, 1'b0, 1'b0);
    run_state({nm, "_main_y"},  S_MAIN_Y,  2, Y, R, 1'b0, 1'b0);
    run_state({nm, "_side_g"},  S_SIDE_G,  6, R, G, 1'b0, 1'b0);
    run_state({nm, "_side_y"},  S_SIDE_Y,  2, R, Y, 1'b0, 1'b0);
  endtask

  task automatic check_main_g(input string nm);
    n_checks++;
    if (state_dbg !== S_MAIN_G || main_lt !== G || side_lt !== R || walk_lt !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: state=%0d main=%b side=%b walk=%b, expected state=0 main=001 side=100 walk=0",
               nm, state_dbg, main_lt, side_lt, walk_lt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; one_hz_en = 1'b0; sensor_sync = 1'b0; wr_sync = 1'b0;
    prog_sync = 1'b0; time_sel = 2'b11; time_value = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_main_g("reset_state");
  endtask

  task automatic test_default_cycle();
    default_cycle("t1");
    check_main_g("t1_wrap");
  endtask

  task automatic test_sensor();
    sensor_sync = 1'b1;
    run_state("t2_main_g",  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state("t2_main_y",  S_MAIN_Y,  2, Y, R, 1'b0, 1'b0);
    run_state("t2_side_g",  S_SIDE_G,  6, R, G, 1'b0, 1'b0);
    run_state("t2_side_gx", S_SIDE_GX, 3, R, G, 1'b0, 1'b0);
    run_state("t2_side_y",  S_SIDE_Y,  2, R, Y, 1'b0, 1'b0);
    sensor_sync = 1'b0;
    check_main_g("t2_wrap");
  endtask

  task automatic test_walk();
    run_state("t3_main_g",  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state("t3_main_g2", S_MAIN_G2, 6, G, R, 1'b0, 1'b0);
    run_state("t3_main_y",  S_MAIN_Y,  2, Y, R, 1'b0, 1'b1);
    run_state("t3_side_g",  S_SIDE_G,  6, R, G, 1'b0, 1'b0);
    run_state("t3_side_y",  S_SIDE_Y,  2, R, Y, 1'b0, 1'b0);
    run_state("t3_walk",    S_WALK,    3, R, R, 1'b1, 1'b0);
    default_cycle("t3_next");
    check_main_g("t3_wrap");
  endtask

  task automatic test_prog_zero_base();
    run_state("t4_main_g",  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state("t4_main_g2", S_MAIN_G2, 6, G, R, 1'b0, 1'b0);
    run_state("t4_main_y",  S_MAIN_Y,  2, Y, R, 1'b0, 1'b0);
    tick();
    tick();
    prog(2'b00, 4'd0, 1'b0, 1'b0);
    run_state("t4_b0_main_g",  S_MAIN_G,  1, G, R, 1'b0, 1'b0);
    run_state("t4_b0_main_g2", S_MAIN_G2, 1, G, R, 1'b0, 1'b0);
    run_state("t4_b0_main_y",  S_MAIN_Y,  2, Y, R, 1'b0, 1'b0);
    run_state("t4_b0_side_g",  S_SIDE_G,  1, R, G, 1'b0, 1'b0);
    run_state("t4_b0_side_y",  S_SIDE_Y,  2, R, Y, 1'b0, 1'b0);
    check_main_g("t4_wrap");
    prog(2'b00, 4'd6, 1'b0, 1'b0);
  endtask

  task automatic test_prog_with_tick();
    tick();
    tick();
    prog(2'b10, 4'd5, 1'b1, 1'b0);
    run_state("t5_main_g",  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state("t5_main_g2", S_MAIN_G2, 6, G, R, 1'b0, 1'b0);
    run_state("t5_main_y",  S_MAIN_Y,  5, Y, R, 1'b0, 1'b0);
    run_state("t5_side_g",  S_SIDE_G,  6, R, G, 1'b0, 1'b0);
    run_state("t5_side_y",  S_SIDE_Y,  5, R, Y, 1'b0, 1'b0);
    check_main_g("t5_wrap");
  endtask

  task automatic test_reset_mid_walk();
    run_state("t6_main_g",  S_MAIN_G,  6, G, R, 1'b0, 1'b0);
    run_state("t6_main_g2", S_MAIN_G2, 6, G, R, 1'b0, 1'b0);
    run_state("t6_main_y",  S_MAIN_Y,  5, Y, R, 1'b0, 1'b1);
    run_state("t6_side_g",  S_SIDE_G,  6, R, G, 1'b0, 1'b0);
    run_state("t6_side_y",  S_SIDE_Y,  5, R, Y, 1'b0, 1'b0);
    n_checks++;
    if (state_dbg !== S_WALK || walk_lt !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_walk_entry: state=%0d walk=%b, expected state=6 walk=1", state_dbg, walk_lt);
    end
    @(negedge clk) wr_sync = 1'b1;
    @(negedge clk) wr_sync = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_main_g("t6_after_reset");
    // No WALK in this cycle and yellow back to 2 ticks.
    default_cycle("t6_post");
    check_main_g("t6_wrap");
  endtask

  task automatic test_prog_and_walk_same_cycle();
    tick();
    prog(2'b11, 4'd9, 1'b0, 1'b1);
    default_cycle("t7");
    run_state("t7_walk", S_WALK, 3, R, R, 1'b1, 1'b0);
    check_main_g("t7_wrap");
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_sensor();
    test_walk();
    test_prog_zero_base();
    test_prog_with_tick();
    test_reset_mid_walk();
    test_prog_and_walk_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
